// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 Set-2 keyboard decoder.
// Pause-key decoding is enabled by defining PS2_DECODER_PAUSE_EN.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
`ifdef PS2_DECODER_PAUSE_EN
    , ST_PAUSE
`endif
  } dec_state_e;

  localparam int EV_W     = 12;
  localparam int EV_RESP  = 11;
  localparam int EV_PAUSE = 10;
  localparam int EV_EXT   = 9;
  localparam int EV_REL   = 8;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_EE = 8'hEE;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;

`ifdef PS2_DECODER_PAUSE_EN
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_LAST = 3'd6;
`endif

  localparam logic [1:0] CSR_EVENT  = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_CTRL   = 2'd2;
  localparam logic [1:0] CSR_RSVD   = 2'd3;

  localparam int STAT_OVF  = 16;
  localparam int CTRL_IEN  = 0;
  localparam int CTRL_FLSH = 1;

  function automatic logic is_resp(
    input logic [7:0] b
  );
    return (b == B_FA) || (b == B_AA) ||
           (b == B_EE) || (b == B_FE) ||
           (b == B_00) || (b == B_FF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: single-clock show-ahead FIFO for key events.
// A push into a full FIFO is accepted only when a pop frees the slot.
module ps2_event_fifo #(
  parameter int aw = 4,
  parameter int dw = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [dw-1:0] din,
  output logic [dw-1:0] dout,
  output logic [aw:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << aw;
  localparam logic [aw-1:0] P_ONE = 1;
  localparam logic [aw:0]   L_ONE = 1;

  logic [dw-1:0] mem_q [DEPTH];
  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [aw:0]   lvl_q, lvl_d;
  logic          do_push, do_pop;

  assign full    = lvl_q[aw];
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;
  assign dout    = mem_q[rp_q];
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush &&
                   (!full || do_pop);

  // pointer and level update; flush empties
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + P_ONE;
      if (do_pop)  rp_d = rp_q + P_ONE;
      if (do_push && !do_pop)
        lvl_d = lvl_q + L_ONE;
      else if (do_pop && !do_push)
        lvl_d = lvl_q - L_ONE;
    end
  end

  // pointer/level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder: Set-2 scancode to key-event decoder with CSR FIFO.
// Define PS2_DECODER_PAUSE_EN to collapse the 8-byte Pause sequence.
module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         fifo_aw  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq
);

  dec_state_e state_q, state_d;
`ifdef PS2_DECODER_PAUSE_EN
  logic [2:0] cnt_q, cnt_d;
`endif

  logic [EV_W-1:0] ev;
  logic            push;
  logic            sel, wr, pop, flush, ov_clr;
  logic            ov_q, ov_d;
  logic            ien_q, ien_d;
  logic            irq_q, irq_d;
  logic [31:0]     rd_q, rd_d;
  logic [EV_W-1:0] head;
  logic [fifo_aw:0] level;
  logic            full, empty;
  logic            unused_bits;

  assign unused_bits = ^{csr_a[9:2],
                         csr_di[31:17],
                         csr_di[15:2]};

  assign sel    = (csr_a[13:10] == csr_addr);
  assign wr     = sel && csr_we;
  assign pop    = wr && (csr_a[1:0] == CSR_EVENT);
  assign ov_clr = wr && (csr_a[1:0] == CSR_STATUS) &&
                  csr_di[STAT_OVF];
  assign flush  = wr && (csr_a[1:0] == CSR_CTRL) &&
                  csr_di[CTRL_FLSH];

  ps2_event_fifo #(
    .aw (fifo_aw),
    .dw (EV_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (ev),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // prefix-tracking decoder: next state and event to push
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ev      = '0;
    ev[7:0] = rx_data;
`ifdef PS2_DECODER_PAUSE_EN
    cnt_d   = cnt_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
`ifdef PS2_DECODER_PAUSE_EN
      cnt_d   = '0;
`endif
    end else if (rx_stb) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            rx_data == B_E0: state_d = ST_E0;
            rx_data == B_F0: state_d = ST_F0;
            rx_data == B_E1: begin
`ifdef PS2_DECODER_PAUSE_EN
              state_d = ST_PAUSE;
              cnt_d   = '0;
`endif
            end
            is_resp(rx_data): begin
              push        = 1'b1;
              ev[EV_RESP] = 1'b1;
            end
            default: push = 1'b1;
          endcase
        end
        ST_E0: begin
          unique case (1'b1)
            rx_data == B_F0: state_d = ST_E0F0;
            rx_data == B_E0: state_d = ST_E0;
            default: begin
              push       = 1'b1;
              ev[EV_EXT] = 1'b1;
              state_d    = ST_IDLE;
            end
          endcase
        end
        ST_F0: begin
          push       = 1'b1;
          ev[EV_REL] = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_E0F0: begin
          push       = 1'b1;
          ev[EV_EXT] = 1'b1;
          ev[EV_REL] = 1'b1;
          state_d    = ST_IDLE;
        end
`ifdef PS2_DECODER_PAUSE_EN
        ST_PAUSE: begin
          if (cnt_q == PAUSE_LAST) begin
            push         = 1'b1;
            ev           = '0;
            ev[EV_PAUSE] = 1'b1;
            ev[7:0]      = PAUSE_CODE;
            state_d      = ST_IDLE;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // CSR side effects, overflow, irq and read mux
  always_comb begin
    ov_d  = ov_q;
    ien_d = ien_q;
    rd_d  = '0;
    if (flush)
      ov_d = 1'b0;
    else if (push && full && !pop)
      ov_d = 1'b1;
    else if (ov_clr)
      ov_d = 1'b0;
    if (wr && (csr_a[1:0] == CSR_CTRL))
      ien_d = csr_di[CTRL_IEN];
    irq_d = ien_q && push && (!full || pop);
    if (sel) begin
      unique case (csr_a[1:0])
        CSR_EVENT: begin
          rd_d[31] = !empty;
          if (!empty) rd_d[EV_W-1:0] = head;
        end
        CSR_STATUS: begin
          rd_d[fifo_aw:0] = level;
          rd_d[STAT_OVF]  = ov_q;
        end
        CSR_CTRL: rd_d[CTRL_IEN] = ien_q;
        CSR_RSVD: rd_d = '0;
      endcase
    end
  end

  // state registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
`ifdef PS2_DECODER_PAUSE_EN
      cnt_q   <= '0;
`endif
      ov_q    <= 1'b0;
      ien_q   <= 1'b0;
      irq_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
`ifdef PS2_DECODER_PAUSE_EN
      cnt_q   <= cnt_d;
`endif
      ov_q    <= ov_d;
      ien_q   <= ien_d;
      irq_q   <= irq_d;
      rd_q    <= rd_d;
    end
  end

  assign csr_do = rd_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// tb_ps2_keyboard_decoder: scoreboard bench for the key-event decoder.
// Reference model tracks prefixes and the event queue abstractly.
module tb_ps2_keyboard_decoder;

  localparam int DEPTH = 16;
  localparam logic [13:0] IDLE_A = 14'h3C00;
  localparam logic [1:0] R_EV = 2'd0;
  localparam logic [1:0] R_ST = 2'd1;
  localparam logic [1:0] R_CT = 2'd2;
  localparam logic [1:0] R_RS = 2'd3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_stb = 1'b0;
  logic [13:0] csr_a = IDLE_A;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        irq;

  ps2_keyboard_decoder dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx_data (rx_data),
    .rx_stb  (rx_stb),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int mon_kind = 0;
  int irq_seen = 0;
  int exp_irq = 0;
  logic [31:0] exp_q[$];

  logic [11:0] mq[$];
  bit m_ext, m_rel, m_ov, m_en;
  int m_pause;

  function automatic void chk(string n,
                              logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction

  function automatic void m_flush();
    mq.delete();
    m_ext = 0;
    m_rel = 0;
    m_pause = 0;
    m_ov = 0;
  endfunction

  function automatic void m_emit(logic [11:0] e, bit en);
    if (mq.size() < DEPTH) begin
      mq.push_back(e);
      if (en) exp_irq++;
    end else begin
      m_ov = 1;
    end
  endfunction

  function automatic bit m_isresp(logic [7:0] b);
    return b == 8'hFA || b == 8'hAA || b == 8'hEE ||
           b == 8'hFE || b == 8'h00 || b == 8'hFF;
  endfunction

  function automatic void m_byte(logic [7:0] b, bit en);
    bit idle;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) m_emit(12'h477, en);
      return;
    end
    idle = !m_ext && !m_rel;
    if (idle && b == 8'hE1) begin
`ifdef PS2_DECODER_PAUSE_EN
      m_pause = 7;
`endif
      return;
    end
    if (!m_rel && b == 8'hE0) begin
      m_ext = 1;
      return;
    end
    if (!m_rel && b == 8'hF0) begin
      m_rel = 1;
      return;
    end
    m_emit({idle && m_isresp(b), 1'b0, m_ext, m_rel, b}, en);
    m_ext = 0;
    m_rel = 0;
  endfunction

  function automatic void m_write(logic [1:0] i,
                                  logic [31:0] d);
    case (i)
      R_EV: if (mq.size() > 0) mq.delete(0);
      R_ST: if (d[16]) m_ov = 0;
      R_CT: begin
        m_en = d[0];
        if (d[1]) m_flush();
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [1:0] i);
    logic [31:0] r;
    r = '0;
    case (i)
      R_EV: if (mq.size() > 0) r = {1'b1, 19'b0, mq[0]};
      R_ST: r = (32'(m_ov) << 16) | 32'(mq.size());
      R_CT: r = 32'(m_en);
      default: r = '0;
    endcase
    return r;
  endfunction

  // one cycle: optional byte, optional CSR write
  task automatic op(input bit sb, input logic [7:0] b,
                    input bit w, input logic [1:0] i,
                    input logic [31:0] d);
    bit en, fl;
    en = m_en;
    fl = w && i == R_CT && d[1];
    rx_data = b;
    rx_stb = sb;
    csr_we = w;
    csr_di = d;
    csr_a = w ? {4'h0, 8'h00, i} : IDLE_A;
    mon_kind = w ? 2 : 0;
    if (w) m_write(i, d);
    if (sb && !fl) m_byte(b, en);
    @(negedge sys_clk);
    rx_stb = 1'b0;
    csr_we = 1'b0;
    csr_a = IDLE_A;
    mon_kind = 0;
  endtask

  task automatic send(input logic [7:0] b);
    op(1, b, 0, R_EV, 0);
  endtask

  task automatic wr(input logic [1:0] i,
                    input logic [31:0] d);
    op(0, 8'h00, 1, i, d);
  endtask

  task automatic rd(input logic [1:0] i);
    exp_q.push_back(m_read(i));
    csr_a = {4'h0, 8'h00, i};
    csr_we = 1'b0;
    mon_kind = 1;
    @(negedge sys_clk);
    csr_a = IDLE_A;
    mon_kind = 0;
  endtask

  task automatic drain();
    rd(R_ST);
    while (mq.size() > 0) begin
      rd(R_EV);
      wr(R_EV, 0);
    end
    rd(R_EV);
    rd(R_ST);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    m_flush();
    m_en = 0;
  endtask

  function automatic logic [7:0] rbyte();
    case ($urandom_range(0, 9))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return 8'hE1;
      3: return 8'hFA;
      4: return 8'hAA;
      5: return 8'h00;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // monitor: compares registered read data and counts irq pulses
  initial begin
    int k;
    logic [31:0] e;
    forever begin
      @(posedge sys_clk);
      k = mon_kind;
      #1;
      if (irq === 1'b1) irq_seen++;
      if (k == 1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_underrun: got read want none");
        end else begin
          e = exp_q.pop_front();
          chk("csr_rd", csr_do, e);
        end
      end else if (k == 0) begin
        chk("csr_idle", csr_do, 32'h0);
      end
    end
  end

  logic [7:0] pseq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                           8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    m_flush();
    m_en = 0;
    @(negedge sys_clk);
    do_reset();
    chk("reset_do", csr_do, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rd(R_ST);
    rd(R_CT);

    send(8'h1C);
    rd(R_ST);
    rd(R_EV);
    wr(R_EV, 0);
    rd(R_EV);
    chk("irq_off", irq_seen, exp_irq);

    wr(R_CT, 32'h1);
    send(8'h1C);
    chk("irq_on", irq_seen, exp_irq);
    rd(R_CT);
    rd(R_RS);
    drain();

    send(8'hF0); send(8'h1C); drain();
    send(8'hE0); send(8'h75); drain();
    send(8'hE0); send(8'hF0); send(8'h75); drain();
    send(8'hE0); send(8'hE0); send(8'h75); drain();
    send(8'hFA); drain();
    send(8'hAA); drain();
    send(8'hF0); send(8'hFA); drain();

    for (int i = 0; i < 8; i++) send(pseq[i]);
    drain();

    for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
    rd(R_ST);
    chk("irq_fill", irq_seen, exp_irq);
    wr(R_ST, 32'h10000);
    rd(R_ST);
    op(1, 8'h41, 1, R_EV, 0);
    rd(R_ST);
    rd(R_EV);
    op(1, 8'h42, 1, R_ST, 32'h10000);
    rd(R_ST);
    drain();

    send(8'hF0);
    wr(R_CT, 32'h3);
    send(8'h1C);
    drain();
    send(8'hF0);
    do_reset();
    send(8'h1C);
    drain();
    op(1, 8'h1C, 1, R_CT, 32'h2);
    rd(R_ST);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: send(rbyte());
        5: rd(R_EV);
        6: wr(R_EV, 0);
        7: rd(R_ST);
        8: op(1, rbyte(), 1, R_EV, 0);
        9: op(1, rbyte(), 1, R_ST,
              32'($urandom_range(0, 1)) << 16);
        10: wr(R_CT, 32'($urandom_range(0, 1)));
        default: begin
          if ($urandom_range(0, 3) == 0)
            op(1, rbyte(), 1, R_CT,
               32'h2 | 32'(m_en));
          else
            rd(R_CT);
        end
      endcase
    end
    drain();
    chk("irq_total", irq_seen, exp_irq);
    @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
